// File: rtl/led_fader_pkg.sv
// -----------------------------------------------------------------------------
// fader_pkg
// Shared types and helpers for the led_fader block and its per-LED channels.
//   fader_state_e : fade controller states (IDLE, FADE)
//   lvl_max()     : full-scale brightness for a given PWM counter width
//   gamma_sq()    : square-law brightness correction, used only when the
//                   LED_FADER_GAMMA_EN build option is defined
// -----------------------------------------------------------------------------
package fader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FADE = 1'b1
    } fader_state_e;

    // Full-scale level: 2^pwm_bits - 1
    function automatic int unsigned lvl_max(input int unsigned pwm_bits);
        return (32'd1 << pwm_bits) - 32'd1;
    endfunction

    // (lvl * lvl) >> pwm_bits; full scale maps to one below full scale
    function automatic logic [31:0] gamma_sq(input logic [15:0] lvl,
                                             input int unsigned pwm_bits);
        logic [31:0] w_sq;
        w_sq = {16'd0, lvl} * {16'd0, lvl};
        return w_sq >> pwm_bits;
    endfunction

endpackage

// File: rtl/led_fader_if.sv
// -----------------------------------------------------------------------------
// led_fader_if
// Pattern-in / LED-out bundle of the led_fader block.
//   pattern : WIDTH-bit LED pattern, sampled only while load = 1
//   load    : single-cycle strobe marking a new pattern
//   led     : registered PWM drive, 1 = LED on
//   busy    : registered, 1 while any channel is still ramping
// Modports: master (pattern source, e.g. ROM side), slave (led_fader).
// -----------------------------------------------------------------------------
interface led_fader_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] pattern;
    logic             load;
    logic [WIDTH-1:0] led;
    logic             busy;

    modport master (
        output pattern,
        output load,
        input  led,
        input  busy
    );

    modport slave (
        input  pattern,
        input  load,
        output led,
        output busy
    );
endinterface

// File: rtl/led_fader_channel.sv
// -----------------------------------------------------------------------------
// fader_channel
// One LED: brightness level register, saturating ramp toward the target,
// brightness-to-duty mapping and the registered PWM compare.
// Build option LED_FADER_GAMMA_EN selects a square-law duty mapping; without
// it the duty follows the level linearly.
// Ports:
//   clock, reset : board clock, async active-high reset
//   i_tgt_on     : 1 = target is full scale, 0 = target is off
//   i_step_en    : ramp tick, move the level one STEP toward the target
//   i_pwm_cnt    : free-running PWM counter from the top
//   o_led        : registered PWM output
//   o_done       : current level equals target
//   o_arrive     : level after the pending step would equal target
//   o_level      : current level
// -----------------------------------------------------------------------------
module fader_channel
    import fader_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_tgt_on,
    input  logic                i_step_en,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led,
    output logic                o_done,
    output logic                o_arrive,
    output logic [PWM_BITS-1:0] o_level
);

    localparam int unsigned         LVL_MAX   = lvl_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] LVL_MAX_V = PWM_BITS'(LVL_MAX);
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = STEP_W[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] r_level;
    logic                r_led;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS:0]   w_lvl_x;
    logic [PWM_BITS:0]   w_tgt_x;
    logic [PWM_BITS-1:0] w_step_lvl;
    logic [PWM_BITS-1:0] w_level_eff;

    assign w_target = i_tgt_on ? LVL_MAX_V : {PWM_BITS{1'b0}};
    assign w_lvl_x  = {1'b0, r_level};
    assign w_tgt_x  = {1'b0, w_target};

    // Candidate level after one step; compares are one bit wider so that
    // level+STEP and target+STEP can never wrap, and the result clamps at target
    always_comb begin
        w_step_lvl = r_level;
        if (w_lvl_x < w_tgt_x) begin
            if ((w_lvl_x + STEP_W) >= w_tgt_x) begin
                w_step_lvl = w_target;
            end else begin
                w_step_lvl = r_level + STEP_N;
            end
        end else if (w_lvl_x > w_tgt_x) begin
            if (w_lvl_x <= (w_tgt_x + STEP_W)) begin
                w_step_lvl = w_target;
            end else begin
                w_step_lvl = r_level - STEP_N;
            end
        end else begin
            w_step_lvl = r_level;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    assign w_level_eff = PWM_BITS'(gamma_sq(16'(r_level), PWM_BITS));
`else
    assign w_level_eff = r_level;
`endif

    // Brightness level register, advanced only on ramp ticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level <= {PWM_BITS{1'b0}};
        end else if (i_step_en) begin
            r_level <= w_step_lvl;
        end else begin
            r_level <= r_level;
        end
    end

    // PWM compare flop: strict greater-than so level 0 is always dark
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_led <= 1'b0;
        end else begin
            r_led <= (w_level_eff > i_pwm_cnt);
        end
    end

    assign o_led    = r_led;
    assign o_done   = (r_level == w_target);
    assign o_arrive = (w_step_lvl == w_target);
    assign o_level  = r_level;

endmodule

// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
// PWM LED driver that ramps every LED toward the most recently loaded pattern
// instead of snapping to it. Owns the free-running PWM counter, the ramp
// divider, the target latch, the IDLE/FADE controller and the busy flag.
// Build option: LED_FADER_GAMMA_EN (square-law duty mapping in the channels).
// Ports:
//   clock : board clock
//   reset : asynchronous, active-high reset
//   bus   : led_fader_if.slave (pattern, load in; led, busy out)
// -----------------------------------------------------------------------------
module led_fader
    import fader_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16,
    parameter int STEP_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    led_fader_if.slave  bus
);

    localparam int unsigned         LVL_MAX   = lvl_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] LVL_MAX_V = PWM_BITS'(LVL_MAX);
    localparam int                  DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [WIDTH-1:0]    r_tgt_on;
    logic                r_busy;
    fader_state_e        r_state;
    fader_state_e        w_state_nxt;

    logic                w_pwm_last;
    logic                w_tick;
    logic                w_step_en;
    logic [WIDTH-1:0]    w_led;
    logic [WIDTH-1:0]    w_done;
    logic [WIDTH-1:0]    w_arrive;
    logic [WIDTH-1:0]    w_new_diff;
    logic [PWM_BITS-1:0] w_level [WIDTH];

    assign w_pwm_last = (r_pwm_cnt == LVL_MAX_V);
    assign w_tick     = w_pwm_last && (r_div_cnt == DIV_LAST);

    // Free-running PWM counter, period 2^PWM_BITS
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
        end else if (w_pwm_last) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Ramp divider: counts whole PWM periods between ramp ticks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (w_pwm_last) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= {DIV_W{1'b0}};
            end else begin
                r_div_cnt <= r_div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_div_cnt <= r_div_cnt;
        end
    end

    // Target latch: one bit per LED, full scale or off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tgt_on <= {WIDTH{1'b0}};
        end else if (bus.load) begin
            r_tgt_on <= bus.pattern;
        end else begin
            r_tgt_on <= r_tgt_on;
        end
    end

    // Controller state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Controller next state; a load always wins over finishing, so a retarget
    // in the tick cycle keeps the fade running toward the new target
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.load && (|w_new_diff)) begin
                    w_state_nxt = FADE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FADE: begin
                if (bus.load) begin
                    w_state_nxt = FADE;
                end else if (w_tick && (&w_arrive)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FADE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Controller outputs: ramp steps happen only on ticks while fading
    always_comb begin
        w_step_en = 1'b0;
        case (r_state)
            FADE:    w_step_en = w_tick;
            IDLE:    w_step_en = 1'b0;
            default: w_step_en = 1'b0;
        endcase
    end

    // Busy flag: registered copy of "some channel not yet at its target"
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= ~(&w_done);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        // Would the incoming pattern move this channel away from its level?
        assign w_new_diff[g] = bus.pattern[g] ? (w_level[g] != LVL_MAX_V)
                                              : (w_level[g] != {PWM_BITS{1'b0}});

        fader_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .i_tgt_on  (r_tgt_on[g]),
            .i_step_en (w_step_en),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g]),
            .o_done    (w_done[g]),
            .o_arrive  (w_arrive[g]),
            .o_level   (w_level[g])
        );
    end

    assign bus.led  = w_led;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// -----------------------------------------------------------------------------
// tb_led_fader
// Bench for led_fader with PWM_BITS=4, STEP=4, STEP_DIV=1 (ramp tick every 16
// clocks). Each table row describes one PWM period ("window"): an optional
// load, the brightness every LED shows during that window and the busy flag.
// The duty of each LED is measured by counting high samples over the window.
// -----------------------------------------------------------------------------
module tb_led_fader;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    led_fader_if #(.WIDTH(5)) bus ();

    led_fader #(
        .WIDTH    (5),
        .PWM_BITS (4),
        .STEP     (4),
        .STEP_DIV (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic             do_load;
        logic [4:0]       pat;
        int               load_at;
        logic             pre_reset;
        logic             quiet;
        logic [4:0][4:0]  lvl;
        logic             busy_s0;
        logic             busy_ld;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt [5];

    // Expected high samples per 16-cycle period for a given level
    function automatic int eff(input int l);
`ifdef LED_FADER_GAMMA_EN
        return (l * l) >> 4;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [4:0] pat, input int at,
                       input logic rs, input logic q,
                       input int l0, input int l1, input int l2, input int l3, input int l4,
                       input logic b0, input logic bld);
        vec_t v;
        v.do_load   = ld;
        v.pat       = pat;
        v.load_at   = at;
        v.pre_reset = rs;
        v.quiet     = q;
        v.lvl[0]    = 5'(l0);
        v.lvl[1]    = 5'(l1);
        v.lvl[2]    = 5'(l2);
        v.lvl[3]    = 5'(l3);
        v.lvl[4]    = 5'(l4);
        v.busy_s0   = b0;
        v.busy_ld   = bld;
        tbl.push_back(v);
    endtask

    // Asynchronous reset landing between clock edges while channel 0 fades up
    task automatic reset_midfade();
        @(posedge clock);
        #1;
        chk("pre_rst_busy", int'(bus.busy), 1);
        chk("pre_rst_led",  int'(bus.led), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_led_now",  int'(bus.led), 0);
        chk("rst_busy_now", int'(bus.busy), 0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_led_hold",  int'(bus.led), 0);
        chk("rst_busy_hold", int'(bus.busy), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.pattern = 5'b00000;

        //  ld    pat       at  rst   quiet  l0  l1  l2  l3  l4  busy_s0 busy_ld
        add(1'b0, 5'b00000, 0,  1'b0, 1'b1,  0,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b1,  0,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b1,  0,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b1,  0,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b1, 5'b00001, 3,  1'b0, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  4,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  8,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 12,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b11111, 3,  1'b0, 1'b0, 15,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 15,  4,  4,  4,  4,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 15,  8,  8,  8,  8,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 15, 12, 12, 12, 12,  1'b1,   1'b0);
        add(1'b1, 5'b00000, 3,  1'b0, 1'b0, 15, 15, 15, 15, 15,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 11, 11, 11, 11, 11,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  7,  7,  7,  7,  7,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  3,  3,  3,  3,  3,  1'b1,   1'b0);
        add(1'b1, 5'b00001, 3,  1'b0, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  4,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b00000, 3,  1'b0, 1'b0,  8,  0,  0,  0,  0,  1'b1,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  4,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b00000, 5,  1'b0, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b1, 5'b00001, 3,  1'b0, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  4,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  8,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 12,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b00001, 7,  1'b0, 1'b0, 15,  0,  0,  0,  0,  1'b0,   1'b0);
        // load lands on the tick edge: that tick uses the old target
        add(1'b1, 5'b00000, 14, 1'b0, 1'b0, 15,  0,  0,  0,  0,  1'b0,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 15,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0, 11,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  7,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  3,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b00001, 3,  1'b0, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  4,  0,  0,  0,  0,  1'b1,   1'b0);
        add(1'b1, 5'b10000, 3,  1'b1, 1'b0,  0,  0,  0,  0,  0,  1'b0,   1'b1);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  0,  0,  0,  0,  4,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  0,  0,  0,  0,  8,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  0,  0,  0,  0, 12,  1'b1,   1'b0);
        add(1'b0, 5'b00000, 0,  1'b0, 1'b0,  0,  0,  0,  0, 15,  1'b0,   1'b0);

        repeat (3) @(posedge clock);
        #1;
        chk("reset_led",  int'(bus.led), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            vec_t e;
            v = tbl[k];
            if (v.pre_reset) reset_midfade();
            sb_q.push_back(v);
            for (int i = 0; i < 5; i++) cnt[i] = 0;
            for (int s = 0; s < 16; s++) begin
                @(posedge clock);
                #1;
                for (int i = 0; i < 5; i++) if (bus.led[i]) cnt[i]++;
                if (s == 0)
                    chk($sformatf("w%0d_busy_s0", k), int'(bus.busy), int'(v.busy_s0));
                if (v.quiet) begin
                    chk($sformatf("w%0d_s%0d_idle_led", k, s), int'(bus.led), 0);
                    chk($sformatf("w%0d_s%0d_idle_busy", k, s), int'(bus.busy), 0);
                end
                if (v.do_load && s == v.load_at + 1) begin
                    bus.load = 1'b0;
                    chk($sformatf("w%0d_busy_at_load", k), int'(bus.busy), int'(v.busy_s0));
                end
                if (v.do_load && s == v.load_at + 2)
                    chk($sformatf("w%0d_busy_after_load", k), int'(bus.busy), int'(v.busy_ld));
                if (v.do_load && s == v.load_at) begin
                    bus.load    = 1'b1;
                    bus.pattern = v.pat;
                end
            end
            e = sb_q.pop_front();
            for (int i = 0; i < 5; i++)
                chk($sformatf("w%0d_duty_ch%0d", k, i), cnt[i], eff(int'(e.lvl[i])));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the pattern ROM in the LED "dance" design.
- Takes each new 5-bit LED pattern and drives the physical LEDs with PWM.
- Each LED ramps its brightness toward the new pattern instead of snapping to it.
- Runs on the fast board clock; a single-cycle load strobe (rising-edge detect of the slow clock, generated at top level) marks a new pattern.

Parameters:
- WIDTH, 5, number of LED channels.
- PWM_BITS, 8, brightness and PWM counter width; LVL_MAX = 2^PWM_BITS-1.
- STEP, 16, brightness change per ramp tick; must be in 1..LVL_MAX.
- STEP_DIV, 4, number of full PWM periods per ramp tick; must be >= 1.

Ports:
- clock  in  1  board clock
- reset  in  1  asynchronous, active-high reset
- pattern  in  WIDTH  LED pattern from the ROM; sampled only when load=1
- load  in  1  single-cycle strobe: new pattern valid
- led  out  WIDTH  registered PWM drive, 1 = LED on
- busy  out  1  registered; 1 while any channel level differs from its target

Behaviour:
- Reset (async, immediate, also mid-fade): pwm_cnt=0, div_cnt=0, all level=0, all target=0, led=0, busy=0, state IDLE.
- PWM counter: pwm_cnt increments every clock and wraps LVL_MAX -> 0 (period 2^PWM_BITS cycles).
- Ramp divider: div_cnt increments when pwm_cnt==LVL_MAX and wraps at STEP_DIV-1.
- Ramp tick: single cycle where pwm_cnt==LVL_MAX and div_cnt==STEP_DIV-1.
- Load: on load=1 at edge N, target[i] = pattern[i] ? LVL_MAX : 0 from edge N.
- Ramp: on each tick, level[i] moves toward target[i] by STEP.
  - Saturate exactly at the target; never overshoot, never wrap.
  - All arithmetic is done PWM_BITS+1 wide before clamping.
- Output compare: led[i] registered as (level_eff[i] > pwm_cnt), one-cycle latency.
  - level 0 gives a constant 0.
  - LVL_MAX gives a duty of LVL_MAX/2^PWM_BITS.
- State machine (states IDLE, FADE):
  - IDLE + load with any new target[i] != level[i] -> FADE; busy=1 from edge N+1.
  - IDLE + load with all new targets equal to levels -> stay IDLE; busy stays 0.
  - FADE + load -> targets overwritten immediately; ramp continues from current levels (retarget, no restart); stay FADE.
  - FADE + tick where all post-step levels equal targets -> IDLE; busy=0 on the following edge.
  - load and tick in the same cycle: the tick steps toward the OLD target; the new target applies from the next tick.
- The pwm_cnt and div_cnt counters free-run regardless of state; load never resets them.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN
- Defined: level_eff[i] = (level[i]*level[i]) >> PWM_BITS, a square-law gamma. level LVL_MAX maps to LVL_MAX-1; 0 maps to 0.
- Undefined: level_eff[i] = level[i] (linear).
- The state machine, busy and ramp timing are identical in both builds.

Decomposition:
- Package fader_pkg holds:
  - state enum {IDLE, FADE};
  - function lvl_max(PWM_BITS);
  - gamma function, used only under the macro.
- Sub-module fader_channel (one instance per LED). Contents: level register, saturating step toward target, gamma/compare, led flop. Outputs its own done flag.
- The top of led_fader owns pwm_cnt, div_cnt, the target latch, the FSM and busy = ~&done.

Test Plan:
Unless stated, benches use PWM_BITS=4, STEP=4, STEP_DIV=1 (LVL_MAX=15, tick every 16 cycles).
- Reset, then 64 idle cycles -> led=5'b00000, busy=0 throughout.
- load pattern=5'b00001 -> busy=1 next edge; level[0] follows 4, 8, 12, 15 on successive ticks. Over the last full PWM period led[0] is high for exactly 15 of 16 cycles; busy drops after the 4th tick; led[4:1] stay 0.
- From all-on (levels 15), load 5'b00000 -> levels 11, 7, 3, 0 (clamp, no wrap); led=0 for a full period afterwards; busy=0.
- Mid-fade retarget: load 5'b00001, after 2 ticks (level 8) load 5'b00000 -> next ticks give 4, 0, with no restart from 15 or 0.
- Reset asserted mid-fade, asynchronously between edges -> led, busy and levels are 0 immediately. After release, load 5'b10000 fades channel 4 only.
- Re-load the identical pattern while IDLE -> busy stays 0 and led waveform is unchanged. With LED_FADER_GAMMA_EN defined and level 15, led[0] is high 14 of 16 cycles.
